// File: rtl/writeback_unit.sv
// Purpose : WB stage of the integer pipeline. Registers the MEM-stage result,
//           formats load data, and arbitrates the single register-file write
//           port between the in-order pipeline and a long-latency unit.
// Latency : 1 cycle from grant to wr_en/wr_addr/wr_data (all registered).
// Backpr. : pipeline wins by default; a long-latency request starved for
//           STARVE_LIMIT cycles forces pipe_stall and takes the port.
// Ports   : clk/rst (async active-high); mem_* MEM-stage inputs; ll_valid/
//           ll_ready handshake with ll_rd_addr/ll_data; pipe_stall to the
//           pipeline; wr_en/wr_addr/wr_data to the register-file write port.
module writeback_unit #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_reg_wr,
  input  logic [4:0]  mem_rd_addr,
  input  logic [1:0]  mem_wb_sel,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_pc_plus4,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd_addr,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  output logic        pipe_stall,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic             pipe_req;
  logic             force_ll;
  logic             ll_grant;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_fmt;
  logic [31:0]      pipe_wdata;

  // Writes to x0 never need the port, so they never compete with the ll unit.
  assign pipe_req = mem_valid & mem_reg_wr & (mem_rd_addr != 5'd0);
  assign force_ll = ll_valid & (cnt_q == LIMIT);

  // Both handshake outputs are gated by rst so a pending request is dropped
  // rather than accepted while the write registers are held cleared.
  assign ll_grant   = ~rst & ll_valid & (force_ll | ~pipe_req);
  assign ll_ready   = ll_grant;
  assign pipe_stall = ~rst & force_ll;

  // Load lane extraction: byte lane from address[1:0], half lane from address[1].
  always_comb begin
    ld_byte = mem_load_data[7:0];
    case (mem_alu_result[1:0])
      2'd0:    ld_byte = mem_load_data[7:0];
      2'd1:    ld_byte = mem_load_data[15:8];
      2'd2:    ld_byte = mem_load_data[23:16];
      default: ld_byte = mem_load_data[31:24];
    endcase
    ld_half = mem_alu_result[1] ? mem_load_data[31:16] : mem_load_data[15:0];
  end

  always_comb begin
    ld_fmt = mem_load_data;
    case (mem_funct3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_fmt = mem_load_data;
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = mem_load_data;
    endcase
  end

  always_comb begin
    pipe_wdata = mem_alu_result;
    case (mem_wb_sel)
      2'b01:   pipe_wdata = ld_fmt;
      2'b10:   pipe_wdata = mem_pc_plus4;
      default: pipe_wdata = mem_alu_result;
    endcase
  end

  // Next-state for the write port. Address/data only move when a write is
  // actually issued; an ll grant to x0 is consumed but leaves them untouched.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (ll_grant) begin
      if (ll_rd_addr != 5'd0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ll_rd_addr;
        wr_data_d = ll_data;
      end
    end else if (pipe_req) begin
      wr_en_d   = 1'b1;
      wr_addr_d = mem_rd_addr;
      wr_data_d = pipe_wdata;
    end
  end

  // Starvation counter: counts refused ll cycles, saturates, and clears on a
  // transfer or when the ll source withdraws.
  always_comb begin
    cnt_d = '0;
    if (ll_valid && !ll_grant) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_reg_wr = 1'b0;
  logic [4:0]  mem_rd_addr = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_load_data = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [31:0] mem_pc_plus4 = '0;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_rd_addr = '0;
  logic [31:0] ll_data = '0;
  logic        ll_ready;
  logic        pipe_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  writeback_unit #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_wr(mem_reg_wr), .mem_rd_addr(mem_rd_addr),
    .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_funct3(mem_funct3),
    .mem_pc_plus4(mem_pc_plus4),
    .ll_valid(ll_valid), .ll_rd_addr(ll_rd_addr), .ll_data(ll_data),
    .ll_ready(ll_ready), .pipe_stall(pipe_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [4:0]  held_a = '0;
  logic [31:0] held_d = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic pipe(input logic v, input logic rw, input logic [4:0] rd,
                      input logic [1:0] sel, input logic [31:0] alu,
                      input logic [2:0] f3, input logic [31:0] pc4);
    mem_valid      = v;
    mem_reg_wr     = rw;
    mem_rd_addr    = rd;
    mem_wb_sel     = sel;
    mem_alu_result = alu;
    mem_funct3     = f3;
    mem_pc_plus4   = pc4;
  endtask

  task automatic ll(input logic v, input logic [4:0] a, input logic [31:0] d);
    ll_valid   = v;
    ll_rd_addr = a;
    ll_data    = d;
  endtask

  // Called one time unit after a rising edge with inputs already applied.
  // Checks the combinational handshake, queues the expected write, then
  // compares it against the port one time unit after the next rising edge.
  task automatic cyc(input string tag, input logic rdy, input logic stall,
                     input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    wr_t got;
    #3;
    check({tag, ":ll_ready"}, {31'd0, ll_ready}, {31'd0, rdy});
    check({tag, ":pipe_stall"}, {31'd0, pipe_stall}, {31'd0, stall});
    if (en) begin
      held_a = a;
      held_d = d;
    end
    e.en = en;
    e.a  = held_a;
    e.d  = held_d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({tag, ":wr_en"}, {31'd0, wr_en}, {31'd0, got.en});
    check({tag, ":wr_addr"}, {27'd0, wr_addr}, {27'd0, got.a});
    check({tag, ":wr_data"}, wr_data, got.d);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ":wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, ":wr_addr"}, {27'd0, wr_addr}, 32'd0);
    check({tag, ":wr_data"}, wr_data, 32'd0);
    check({tag, ":ll_ready"}, {31'd0, ll_ready}, 32'd0);
    check({tag, ":pipe_stall"}, {31'd0, pipe_stall}, 32'd0);
  endtask

  initial begin
    // Reset with a pending ll request: nothing accepted, outputs cleared.
    ll(1'b1, 5'd3, 32'h0000_0033);
    #3;
    reset_checks("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ll(1'b0, 5'd0, 32'd0);
    held_a = '0;
    held_d = '0;

    cyc("idle0", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // ALU write, then an idle cycle holding address/data.
    pipe(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234_5678, 3'b000, 32'd0);
    cyc("alu", 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
    pipe(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 3'b000, 32'd0);
    cyc("idle1", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Load formatting on load_data = 0x80FF_7F01.
    mem_load_data = 32'h80FF_7F01;
    pipe(1'b1, 1'b1, 5'd6, 2'b01, 32'h0000_1003, 3'b000, 32'd0);
    cyc("lb3", 1'b0, 1'b0, 1'b1, 5'd6, 32'hFFFF_FF80);
    pipe(1'b1, 1'b1, 5'd7, 2'b01, 32'h0000_1001, 3'b100, 32'd0);
    cyc("lbu1", 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_007F);
    pipe(1'b1, 1'b1, 5'd8, 2'b01, 32'h0000_1002, 3'b001, 32'd0);
    cyc("lh1", 1'b0, 1'b0, 1'b1, 5'd8, 32'hFFFF_80FF);
    pipe(1'b1, 1'b1, 5'd9, 2'b01, 32'h0000_1000, 3'b101, 32'd0);
    cyc("lhu0", 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_7F01);
    pipe(1'b1, 1'b1, 5'd10, 2'b01, 32'h0000_1000, 3'b010, 32'd0);
    cyc("lw", 1'b0, 1'b0, 1'b1, 5'd10, 32'h80FF_7F01);
    pipe(1'b1, 1'b1, 5'd11, 2'b01, 32'h0000_1002, 3'b011, 32'd0);
    cyc("ld_other", 1'b0, 1'b0, 1'b1, 5'd11, 32'h80FF_7F01);
    pipe(1'b1, 1'b1, 5'd1, 2'b10, 32'h0000_0ABC, 3'b000, 32'h0000_0100);
    cyc("jal", 1'b0, 1'b0, 1'b1, 5'd1, 32'h0000_0100);
    pipe(1'b1, 1'b1, 5'd12, 2'b11, 32'h0BAD_F00D, 3'b000, 32'h0000_0200);
    cyc("sel11", 1'b0, 1'b0, 1'b1, 5'd12, 32'h0BAD_F00D);

    // ll accepted alongside a store (no rd write).
    pipe(1'b1, 1'b0, 5'd4, 2'b00, 32'h0000_0040, 3'b010, 32'd0);
    ll(1'b1, 5'd9, 32'hDEAD_BEEF);
    cyc("ll_store", 1'b1, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF);
    ll(1'b0, 5'd0, 32'd0);
    pipe(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 3'b000, 32'd0);
    cyc("idle2", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Starvation: 4 refused cycles, then a forced ll write, then the held pipe op.
    ll(1'b1, 5'd20, 32'hCAFE_0001);
    for (int i = 0; i < 4; i++) begin
      pipe(1'b1, 1'b1, 5'(13 + i), 2'b00, 32'hA000_0000 + 32'(i), 3'b000, 32'd0);
      cyc($sformatf("starve%0d", i), 1'b0, 1'b0, 1'b1, 5'(13 + i), 32'hA000_0000 + 32'(i));
    end
    pipe(1'b1, 1'b1, 5'd17, 2'b00, 32'hA000_00A5, 3'b000, 32'd0);
    cyc("force", 1'b1, 1'b1, 1'b1, 5'd20, 32'hCAFE_0001);
    ll(1'b0, 5'd0, 32'd0);
    cyc("held_pipe", 1'b0, 1'b0, 1'b1, 5'd17, 32'hA000_00A5);

    // Counter must be back at 0: a new ll request waits another full 4 cycles.
    ll(1'b1, 5'd21, 32'hCAFE_0002);
    for (int i = 0; i < 2; i++) begin
      pipe(1'b1, 1'b1, 5'(22 + i), 2'b00, 32'hB000_0000 + 32'(i), 3'b000, 32'd0);
      cyc($sformatf("restarve%0d", i), 1'b0, 1'b0, 1'b1, 5'(22 + i), 32'hB000_0000 + 32'(i));
    end

    // Reset mid-stream with ll_valid and pipe_req still asserted.
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    @(posedge clk);
    #1;
    reset_checks("midrst_hold");
    rst = 1'b0;
    held_a = '0;
    held_d = '0;

    // After release the counter restarts from 0: 4 refused cycles before force.
    for (int i = 0; i < 4; i++) begin
      pipe(1'b1, 1'b1, 5'(24 + i), 2'b00, 32'hC000_0000 + 32'(i), 3'b000, 32'd0);
      cyc($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b1, 5'(24 + i), 32'hC000_0000 + 32'(i));
    end
    pipe(1'b1, 1'b1, 5'd28, 2'b00, 32'hC000_00FF, 3'b000, 32'd0);
    cyc("post_rst_force", 1'b1, 1'b1, 1'b1, 5'd21, 32'hCAFE_0002);
    ll(1'b0, 5'd0, 32'd0);
    cyc("post_rst_held", 1'b0, 1'b0, 1'b1, 5'd28, 32'hC000_00FF);

    // Pipe write to x0 does not compete with ll.
    pipe(1'b1, 1'b1, 5'd0, 2'b00, 32'h5555_5555, 3'b000, 32'd0);
    ll(1'b1, 5'd7, 32'h0000_0077);
    cyc("x0_with_ll", 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0077);
    ll(1'b0, 5'd0, 32'd0);
    cyc("x0_alone", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // ll to x0 is consumed but produces no write.
    pipe(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 3'b000, 32'd0);
    ll(1'b1, 5'd0, 32'h1111_1111);
    cyc("ll_x0", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    ll(1'b0, 5'd0, 32'd0);
    cyc("idle3", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side driver of the integer register file.
- Registers MEM-stage results into a WB stage, formats load data, and selects the write-back value.
- Arbitrates the single register-file write port between the in-order pipeline and a long-latency unit (divider/multi-cycle ops) that uses a valid/ready handshake.
- Outputs wr_en/wr_addr/wr_data connect directly to the register file write port.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles ll_valid may wait without grant before the pipeline is stalled to force an ll write (1..15).
- CNT_W, 4: width of the starvation counter. It must hold STARVE_LIMIT.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- mem_valid  input  1  MEM-stage instruction valid
- mem_reg_wr  input  1  instruction writes rd
- mem_rd_addr  input  5  destination register
- mem_wb_sel  input  2  00 ALU result, 01 load data, 10 PC+4, 11 ALU result
- mem_alu_result  input  32  ALU result / load effective address
- mem_load_data  input  32  aligned 32-bit word read from data memory
- mem_funct3  input  3  load size/sign code
- mem_pc_plus4  input  32  link value for JAL/JALR
- ll_valid  input  1  long-latency result available
- ll_rd_addr  input  5  long-latency destination
- ll_data  input  32  long-latency result
- ll_ready  output  1  long-latency result accepted this cycle (combinational)
- pipe_stall  output  1  pipeline must hold the MEM stage this cycle (combinational)
- wr_en  output  1  register-file write enable (registered)
- wr_addr  output  5  register-file write address (registered)
- wr_data  output  32  register-file write data (registered)

Behaviour:
- Reset (asynchronous, while rst=1): wr_en=0, wr_addr=0, wr_data=0, starvation counter=0.
- During reset, ll_ready=0 and pipe_stall=0.
- Pipe request: pipe_req = mem_valid & mem_reg_wr & (mem_rd_addr != 0).
  - A pipe instruction without pipe_req needs no slot and is always consumed with no stall.
- Force condition: force = ll_valid & (cnt == STARVE_LIMIT).
- Grant rules, evaluated each cycle:
  - If force: pipe_stall=1, ll_ready=1, ll granted. The pipe inputs are ignored this cycle. The pipe must hold mem_* stable and re-present next cycle.
  - Else if pipe_req: pipe granted, ll_ready=0, pipe_stall=0.
  - Else: ll_ready=ll_valid, pipe_stall=0.
- Latency is exactly 1 cycle. The granted source's address and data appear on wr_addr/wr_data with wr_en=1 at the next rising edge.
  - With no grant, wr_en=0 next cycle and wr_addr/wr_data hold their previous values.
- ll handshake:
  - A transfer occurs when ll_valid & ll_ready.
  - ll_rd_addr/ll_data must stay stable while ll_valid=1 and ll_ready=0.
  - ll_rd_addr==0 is still granted and consumed, but produces wr_en=0.
- Starvation counter:
  - Increments on each cycle with ll_valid=1 and ll_ready=0, saturating at STARVE_LIMIT.
  - Clears on an ll transfer or when ll_valid=0.
- Write-data selection for pipe grants:
  - 00/11 → mem_alu_result.
  - 10 → mem_pc_plus4.
  - 01 → formatted load.
- Load formatting, with byte lane chosen by mem_alu_result[1:0] and half lane by mem_alu_result[1]:
  - funct3 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other codes: full word.
- Write ordering between the two sources to the same rd is the issuer's responsibility. This block never reorders or merges writes.
- Reset mid-handshake: a pending ll request is dropped. The counter clears, and the source must re-present after reset.

Test Plan:
- Reset mid-stream with ll_valid=1 → wr_en=0, ll_ready=0, pipe_stall=0 immediately; the counter restarts at 0 after release.
- Pipe ALU write rd=5, alu=0x1234_5678, wb_sel=00 → next cycle wr_en=1, wr_addr=5, wr_data=0x1234_5678; following idle cycle wr_en=0.
- Loads with load_data=0x80FF_7F01:
  - LB addr[1:0]=3 → 0xFFFF_FF80.
  - LBU addr[1:0]=1 → 0x0000_007F.
  - LH addr[1]=1 → 0xFFFF_80FF.
  - LHU addr[1]=0 → 0x0000_7F01.
  - JAL wb_sel=10, pc_plus4=0x100 → 0x100.
- ll_valid with rd=9, data=0xDEAD_BEEF during a pipe store (reg_wr=0) → ll_ready=1 same cycle; next cycle wr_en=1, wr_addr=9, wr_data=0xDEAD_BEEF.
- Continuous pipe_req writes plus ll_valid, STARVE_LIMIT=4 → ll_ready=0 for 4 cycles; 5th cycle pipe_stall=1 and ll_ready=1; next cycle writes ll data; held pipe instruction written the cycle after; counter back to 0.
- Pipe write to rd=0 alongside ll_valid → no stall, ll granted; pipe write to rd=0 alone → wr_en stays 0.
